// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: for each accepted sample, steps the coefficient address
// through every tap, issues MAC commands and rotates across interleaved channels.
package fir_filter_pkg;
  localparam logic [1:0] MAC_NOP  = 2'd0;
  localparam logic [1:0] MAC_CLR  = 2'd1;
  localparam logic [1:0] MAC_LOAD = 2'd2;
  localparam logic [1:0] MAC_ACC  = 2'd3;
endpackage

module fir_tap_sequencer
  import fir_filter_pkg::*;
#(
  parameter int NTAPS     = 8,
  parameter int NCHANNELS = 2,
  localparam int FADDRBITS = $clog2(NTAPS),
  localparam int CHBITS    = (NCHANNELS > 1) ? $clog2(NCHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 filter_en_in,
  input  logic                 sample_strobe_in,
  output logic                 sample_ready_out,
  output logic                 clr_out,
  output logic                 dwe_out,
  output logic [FADDRBITS-1:0] faddr_out,
  output logic [CHBITS-1:0]    ch_out,
  output logic [1:0]           mctrl_out,
  output logic                 oload_out,
  output logic                 busy_out,
  output logic                 overrun_out
);

  typedef enum logic [2:0] {
    ST_STOPPED = 3'd0,
    ST_IDLE    = 3'd1,
    ST_READ    = 3'd2,
    ST_TAP     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [FADDRBITS-1:0] LAST_TAP = FADDRBITS'(NTAPS - 1);
  localparam logic [CHBITS-1:0]    LAST_CH  = CHBITS'(NCHANNELS - 1);

  state_t               state;
  logic [FADDRBITS-1:0] tap_cnt;

  // Outputs are registered alongside the next state, so each one reflects
  // the state the machine is entering rather than the one it is leaving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_STOPPED;
      tap_cnt          <= '0;
      ch_out           <= '0;
      overrun_out      <= 1'b0;
      sample_ready_out <= 1'b0;
      clr_out          <= 1'b1;
      dwe_out          <= 1'b0;
      faddr_out        <= '0;
      mctrl_out        <= MAC_CLR;
      oload_out        <= 1'b0;
      busy_out         <= 1'b0;
    end else begin
      sample_ready_out <= 1'b0;
      clr_out          <= 1'b0;
      dwe_out          <= 1'b0;
      faddr_out        <= '0;
      mctrl_out        <= MAC_NOP;
      oload_out        <= 1'b0;
      busy_out         <= 1'b0;

      if (!filter_en_in) begin
        state       <= ST_STOPPED;
        tap_cnt     <= '0;
        ch_out      <= '0;
        overrun_out <= 1'b0;
        clr_out     <= 1'b1;
        mctrl_out   <= MAC_CLR;
      end else begin
        case (state)
          ST_STOPPED: begin
            state            <= ST_IDLE;
            sample_ready_out <= 1'b1;
          end
          ST_IDLE: begin
            if (sample_strobe_in) begin
              state    <= ST_READ;
              tap_cnt  <= '0;
              dwe_out  <= 1'b1;
              busy_out <= 1'b1;
            end else begin
              sample_ready_out <= 1'b1;
            end
          end
          ST_READ: begin
            state     <= ST_TAP;
            tap_cnt   <= '0;
            faddr_out <= '0;
            mctrl_out <= MAC_LOAD;
            busy_out  <= 1'b1;
            if (sample_strobe_in) overrun_out <= 1'b1;
          end
          ST_TAP: begin
            busy_out <= 1'b1;
            if (sample_strobe_in) overrun_out <= 1'b1;
            if (tap_cnt == LAST_TAP) begin
              state     <= ST_DONE;
              oload_out <= 1'b1;
            end else begin
              tap_cnt   <= tap_cnt + 1'b1;
              faddr_out <= tap_cnt + 1'b1;
              mctrl_out <= MAC_ACC;
            end
          end
          ST_DONE: begin
            state            <= ST_IDLE;
            sample_ready_out <= 1'b1;
            ch_out           <= (ch_out == LAST_CH) ? '0 : ch_out + 1'b1;
            if (sample_strobe_in) overrun_out <= 1'b1;
          end
          default: begin
            // Corrupted encoding: recover through the same path as a disable.
            state       <= ST_STOPPED;
            tap_cnt     <= '0;
            ch_out      <= '0;
            overrun_out <= 1'b0;
            clr_out     <= 1'b1;
            mctrl_out   <= MAC_CLR;
          end
        endcase
      end
    end
  end

endmodule
